debug_telemetry_mc: RTL and testbench

Multi-channel debug/telemetry block with two parts.
- A bank of NUM_EVT generic event counters.
- An armable PC/instruction trace ring buffer with selectable trigger mode and a programmable post-trigger window.
It sits beside the core and takes retire/PC/instr taps plus per-event pulses. A CSR/MMIO adapter drives the arm/config inputs and reads counters and trace contents.

---
 rtl/debug_telemetry_mc_pkg.sv | 21 ++
 rtl/debug_telemetry_mc_if.sv | 49 ++++
 rtl/debug_telemetry_mc_ram.sv | 27 ++
 rtl/debug_telemetry_mc.sv | 137 +++++++++++++
 tb/tb_debug_telemetry_mc.sv | 225 ++++++++++++++++++++++
 5 files changed

// File: rtl/debug_telemetry_mc_pkg.sv
// Shared types and widths for the debug/telemetry block: trace FSM states,
// trigger modes and the PC/instruction tap widths.
package dbg_tlm_pkg;
  localparam int PC_W    = 32;
  localparam int INSTR_W = 32;
  localparam int SAMP_W  = 16;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ARMED = 2'd1,
    POST  = 2'd2,
    DONE  = 2'd3
  } trace_state_e;

  typedef enum logic [1:0] {
    TRIG_EXT    = 2'd0,
    TRIG_CNT    = 2'd1,
    TRIG_PC     = 2'd2,
    TRIG_EXT_PC = 2'd3
  } trig_mode_e;
endpackage

// File: rtl/debug_telemetry_mc_if.sv
// Core taps, CSR-side configuration and readback signals of debug_telemetry_mc.
// The slave modport is the block itself; the master side is the core/CSR adapter.
interface debug_telemetry_mc_if #(
  parameter int NUM_EVT     = 4,
  parameter int CNT_WIDTH   = 64,
  parameter int TRACE_DEPTH = 64
);
  import dbg_tlm_pkg::*;
  localparam int PTR_W = $clog2(TRACE_DEPTH);
  localparam int SEL_W = (NUM_EVT > 1) ? $clog2(NUM_EVT) : 1;

  logic [NUM_EVT-1:0]   evt_i;
  logic                 cnt_en_i;
  logic                 cnt_clr_i;
  logic [SEL_W-1:0]     cnt_sel_i;
  logic [CNT_WIDTH-1:0] cnt_val_o;
  logic [NUM_EVT-1:0]   cnt_ovf_o;
  logic                 retire_valid_i;
  logic [PC_W-1:0]      pc_i;
  logic [INSTR_W-1:0]   instr_i;
  logic                 arm_i;
  logic [1:0]           trig_mode_i;
  logic                 ext_trig_i;
  logic [PC_W-1:0]      trig_pc_i;
  logic [SAMP_W-1:0]    trig_cnt_i;
  logic [PTR_W-1:0]     post_cnt_i;
  logic [1:0]           state_o;
  logic                 triggered_o;
  logic [PTR_W-1:0]     wr_ptr_o;
  logic                 wrapped_o;
  logic [PTR_W-1:0]     trig_idx_o;
  logic [PTR_W-1:0]     rd_addr_i;
  logic [PC_W-1:0]      rd_pc_o;
  logic [INSTR_W-1:0]   rd_instr_o;

  modport slave (
    input  evt_i, cnt_en_i, cnt_clr_i, cnt_sel_i, retire_valid_i, pc_i, instr_i,
           arm_i, trig_mode_i, ext_trig_i, trig_pc_i, trig_cnt_i, post_cnt_i, rd_addr_i,
    output cnt_val_o, cnt_ovf_o, state_o, triggered_o, wr_ptr_o, wrapped_o,
           trig_idx_o, rd_pc_o, rd_instr_o
  );

  modport master (
    output evt_i, cnt_en_i, cnt_clr_i, cnt_sel_i, retire_valid_i, pc_i, instr_i,
           arm_i, trig_mode_i, ext_trig_i, trig_pc_i, trig_cnt_i, post_cnt_i, rd_addr_i,
    input  cnt_val_o, cnt_ovf_o, state_o, triggered_o, wr_ptr_o, wrapped_o,
           trig_idx_o, rd_pc_o, rd_instr_o
  );
endinterface

// File: rtl/debug_telemetry_mc_ram.sv
// Trace storage: one synchronous write port, one registered read port.
// Kept behind this boundary so it can be replaced by an SRAM macro.
module trace_ram_1w1r #(
  parameter  int DEPTH = 64,
  parameter  int WIDTH = 64,
  localparam int AW    = $clog2(DEPTH)
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             we_i,
  input  logic [AW-1:0]    waddr_i,
  input  logic [WIDTH-1:0] wdata_i,
  input  logic [AW-1:0]    raddr_i,
  output logic [WIDTH-1:0] rdata_o
);
  logic [WIDTH-1:0] r_mem [DEPTH];

  always_ff @(posedge clk_i) begin
    if (we_i) r_mem[waddr_i] <= wdata_i;
  end

  // Read samples the array before this edge's write lands: same-index reads see old data.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) rdata_o <= '0;
    else         rdata_o <= r_mem[raddr_i];
  end
endmodule

// File: rtl/debug_telemetry_mc.sv
// Event counter bank plus armable PC/instruction trace ring with trigger
// selection and a post-trigger capture window.
module debug_telemetry_mc
  import dbg_tlm_pkg::*;
#(
  parameter int NUM_EVT     = 4,
  parameter int CNT_WIDTH   = 64,
  parameter int TRACE_DEPTH = 64
) (
  input logic                 clk_i,
  input logic                 rst_ni,
  debug_telemetry_mc_if.slave bus
);
  localparam int PTR_W = $clog2(TRACE_DEPTH);

  logic [NUM_EVT-1:0][CNT_WIDTH-1:0] r_cnt;
  logic [NUM_EVT-1:0]                r_ovf;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_cnt <= '0;
      r_ovf <= '0;
    end else if (bus.cnt_clr_i) begin
      r_cnt <= '0;
      r_ovf <= '0;
    end else if (bus.cnt_en_i) begin
      for (int k = 0; k < NUM_EVT; k++) begin
        if (bus.evt_i[k]) begin
          r_cnt[k] <= r_cnt[k] + CNT_WIDTH'(1);
          if (&r_cnt[k]) r_ovf[k] <= 1'b1;
        end
      end
    end
  end

  assign bus.cnt_val_o = (32'(bus.cnt_sel_i) < NUM_EVT) ? r_cnt[bus.cnt_sel_i] : '0;
  assign bus.cnt_ovf_o = r_ovf;

  trace_state_e      r_state, w_state_nx;
  logic [PTR_W-1:0]  r_wr_ptr, w_wr_ptr_nx, r_trig_idx, w_trig_idx_nx, r_remain, w_remain_nx;
  logic              r_wrapped, w_wrapped_nx;
  logic [SAMP_W-1:0] r_samp, w_samp_nx;
  logic              w_we, w_capt, w_pc_hit, w_cnt_hit, w_trig;
  logic [PTR_W-1:0]  w_waddr;
  logic [PC_W+INSTR_W-1:0] w_rd_q;

  assign w_capt    = (r_state == ARMED) || (r_state == POST);
  assign w_pc_hit  = bus.retire_valid_i && (bus.pc_i == bus.trig_pc_i);
  // trig_cnt 0 is treated like 1: fire on the very first retire.
  assign w_cnt_hit = bus.retire_valid_i &&
                     ((bus.trig_cnt_i == '0) ? (r_samp == '0)
                                             : (r_samp == bus.trig_cnt_i - SAMP_W'(1)));

  always_comb begin
    w_trig = 1'b0;
    case (trig_mode_e'(bus.trig_mode_i))
      TRIG_EXT: w_trig = bus.ext_trig_i;
      TRIG_CNT: w_trig = w_cnt_hit;
      TRIG_PC:  w_trig = w_pc_hit;
      default:  w_trig = bus.ext_trig_i || w_pc_hit;
    endcase
  end

  always_comb begin
    w_state_nx    = r_state;
    w_wr_ptr_nx   = r_wr_ptr;
    w_wrapped_nx  = r_wrapped;
    w_trig_idx_nx = r_trig_idx;
    w_remain_nx   = r_remain;
    w_samp_nx     = r_samp;
    w_we          = 1'b0;
    w_waddr       = r_wr_ptr;
    if (bus.arm_i) begin
      // Re-arm wins over trigger/completion; this cycle's retire becomes sample 0.
      w_state_nx    = ARMED;
      w_wrapped_nx  = 1'b0;
      w_trig_idx_nx = '0;
      w_remain_nx   = '0;
      w_we          = bus.retire_valid_i;
      w_waddr       = '0;
      w_wr_ptr_nx   = bus.retire_valid_i ? PTR_W'(1) : '0;
      w_samp_nx     = bus.retire_valid_i ? SAMP_W'(1) : '0;
    end else if (w_capt) begin
      if (bus.retire_valid_i) begin
        w_we        = 1'b1;
        w_wr_ptr_nx = r_wr_ptr + PTR_W'(1);
        if (&r_wr_ptr) w_wrapped_nx = 1'b1;
        if (!(&r_samp)) w_samp_nx = r_samp + SAMP_W'(1);
      end
      if (r_state == ARMED && w_trig) begin
        w_trig_idx_nx = bus.retire_valid_i ? r_wr_ptr : r_wr_ptr - PTR_W'(1);
        w_remain_nx   = bus.post_cnt_i;
        w_state_nx    = (bus.post_cnt_i == '0) ? DONE : POST;
      end else if (r_state == POST && bus.retire_valid_i) begin
        w_remain_nx = r_remain - PTR_W'(1);
        if (r_remain == PTR_W'(1)) w_state_nx = DONE;
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_state    <= IDLE;
      r_wr_ptr   <= '0;
      r_wrapped  <= 1'b0;
      r_trig_idx <= '0;
      r_remain   <= '0;
      r_samp     <= '0;
    end else begin
      r_state    <= w_state_nx;
      r_wr_ptr   <= w_wr_ptr_nx;
      r_wrapped  <= w_wrapped_nx;
      r_trig_idx <= w_trig_idx_nx;
      r_remain   <= w_remain_nx;
      r_samp     <= w_samp_nx;
    end
  end

  assign bus.state_o     = r_state;
  assign bus.triggered_o = (r_state == POST) || (r_state == DONE);
  assign bus.wr_ptr_o    = r_wr_ptr;
  assign bus.wrapped_o   = r_wrapped;
  assign bus.trig_idx_o  = r_trig_idx;

  trace_ram_1w1r #(.DEPTH(TRACE_DEPTH), .WIDTH(PC_W + INSTR_W)) u_ram (
    .clk_i   (clk_i),
    .rst_ni  (rst_ni),
    .we_i    (w_we),
    .waddr_i (w_waddr),
    .wdata_i ({bus.pc_i, bus.instr_i}),
    .raddr_i (bus.rd_addr_i),
    .rdata_o (w_rd_q)
  );

  assign bus.rd_pc_o    = w_rd_q[PC_W+INSTR_W-1:INSTR_W];
  assign bus.rd_instr_o = w_rd_q[INSTR_W-1:0];
endmodule

// File: tb/tb_debug_telemetry_mc.sv
// Directed bench: u0 is the default build (64b counters, 64-deep trace),
// u1 a small build (8b counters, 8-deep trace) for wrap/overflow cases.
module tb_debug_telemetry_mc;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   n_chk = 0;
  int   n_bad = 0;

  always #5 clk = ~clk;

  debug_telemetry_mc_if #(.NUM_EVT(4), .CNT_WIDTH(64), .TRACE_DEPTH(64)) if0 ();
  debug_telemetry_mc_if #(.NUM_EVT(4), .CNT_WIDTH(8),  .TRACE_DEPTH(8))  if1 ();

  debug_telemetry_mc #(.NUM_EVT(4), .CNT_WIDTH(64), .TRACE_DEPTH(64)) u0 (
    .clk_i(clk), .rst_ni(rst_n), .bus(if0));
  debug_telemetry_mc #(.NUM_EVT(4), .CNT_WIDTH(8), .TRACE_DEPTH(8)) u1 (
    .clk_i(clk), .rst_ni(rst_n), .bus(if1));

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h want %0h", tag, got, exp);
    end
  endtask

  task automatic tick(input int n = 1);
    repeat (n) @(posedge clk);
    #1;
  endtask

  initial begin
    {if0.evt_i, if0.cnt_en_i, if0.cnt_clr_i, if0.cnt_sel_i, if0.retire_valid_i} = '0;
    {if0.pc_i, if0.instr_i, if0.arm_i, if0.trig_mode_i, if0.ext_trig_i} = '0;
    {if0.trig_pc_i, if0.trig_cnt_i, if0.post_cnt_i, if0.rd_addr_i} = '0;
    {if1.evt_i, if1.cnt_en_i, if1.cnt_clr_i, if1.cnt_sel_i, if1.retire_valid_i} = '0;
    {if1.pc_i, if1.instr_i, if1.arm_i, if1.trig_mode_i, if1.ext_trig_i} = '0;
    {if1.trig_pc_i, if1.trig_cnt_i, if1.post_cnt_i, if1.rd_addr_i} = '0;

    // reset state
    tick(2);
    chk("rst_state",   64'(if0.state_o), 64'd0);
    chk("rst_wr_ptr",  64'(if0.wr_ptr_o), 64'd0);
    chk("rst_trig",    64'({if0.triggered_o, if0.wrapped_o}), 64'd0);
    chk("rst_tidx",    64'(if0.trig_idx_o), 64'd0);
    chk("rst_cnt",     64'(if0.cnt_val_o), 64'd0);
    chk("rst_ovf",     64'(if0.cnt_ovf_o), 64'd0);
    chk("rst_rd",      64'({if0.rd_pc_o, if0.rd_instr_o}), 64'd0);
    rst_n = 1'b1;
    tick();

    // counters: channels 0 and 2 count 10 events
    if0.cnt_en_i = 1'b1;
    if0.evt_i = 4'b0101;
    tick(10);
    if0.evt_i = 4'b0000;
    for (int k = 0; k < 4; k++) begin
      if0.cnt_sel_i = 2'(k);
      #1;
      chk($sformatf("cnt%0d", k), 64'(if0.cnt_val_o), (k % 2 == 0) ? 64'd10 : 64'd0);
    end
    if0.cnt_clr_i = 1'b1;
    if0.evt_i = 4'b1111;
    tick();
    if0.cnt_clr_i = 1'b0;
    if0.evt_i = 4'b0000;
    if0.cnt_sel_i = 2'd0;
    #1;
    chk("clr_cnt0", 64'(if0.cnt_val_o), 64'd0);
    if0.cnt_sel_i = 2'd3;
    #1;
    chk("clr_cnt3", 64'(if0.cnt_val_o), 64'd0);

    // overflow on the 8-bit build
    if1.cnt_en_i = 1'b1;
    if1.cnt_sel_i = 2'd1;
    if1.evt_i = 4'b0010;
    tick(255);
    chk("ovf_pre_cnt", 64'(if1.cnt_val_o), 64'd255);
    chk("ovf_pre_flag", 64'(if1.cnt_ovf_o), 64'd0);
    tick();
    if1.evt_i = 4'b0000;
    #1;
    chk("ovf_cnt", 64'(if1.cnt_val_o), 64'd0);
    chk("ovf_flag", 64'(if1.cnt_ovf_o), 64'b0010);
    if1.evt_i = 4'b0010;
    if1.cnt_clr_i = 1'b1;
    tick();
    if1.cnt_clr_i = 1'b0;
    if1.evt_i = 4'b0000;
    #1;
    chk("ovf_clr_cnt", 64'(if1.cnt_val_o), 64'd0);
    chk("ovf_clr_flag", 64'(if1.cnt_ovf_o), 64'd0);

    // count trigger: 5th sample triggers, 3 more captured
    if0.trig_mode_i = 2'd1;
    if0.trig_cnt_i = 16'd5;
    if0.post_cnt_i = 6'd3;
    if0.arm_i = 1'b1;
    tick();
    if0.arm_i = 1'b0;
    chk("cnt_armed", 64'(if0.state_o), 64'd1);
    for (int n = 0; n < 20; n++) begin
      if0.retire_valid_i = 1'b1;
      if0.pc_i = 32'h100 + 32'(4 * n);
      if0.instr_i = 32'hA000_0000 + 32'(n);
      tick();
      if (n == 4) begin
        chk("cnt_post", 64'(if0.state_o), 64'd2);
        chk("cnt_trig", 64'(if0.triggered_o), 64'd1);
      end
      if (n == 6) chk("cnt_still_post", 64'(if0.state_o), 64'd2);
      if (n == 7) chk("cnt_done", 64'(if0.state_o), 64'd3);
    end
    if0.retire_valid_i = 1'b0;
    chk("cnt_tidx", 64'(if0.trig_idx_o), 64'd4);
    chk("cnt_wptr", 64'(if0.wr_ptr_o), 64'd8);
    chk("cnt_wrap", 64'(if0.wrapped_o), 64'd0);
    for (int a = 0; a < 8; a++) begin
      if0.rd_addr_i = 6'(a);
      tick();
      chk($sformatf("cnt_rd%0d", a), 64'(if0.rd_pc_o), 64'h100 + 64'(4 * a));
    end
    chk("cnt_rd_instr7", 64'(if0.rd_instr_o), 64'hA000_0007);

    // external trigger without retire, post window 0
    if0.trig_mode_i = 2'd0;
    if0.post_cnt_i = 6'd0;
    if0.arm_i = 1'b1;
    tick();
    if0.arm_i = 1'b0;
    for (int n = 0; n < 3; n++) begin
      if0.retire_valid_i = 1'b1;
      if0.pc_i = 32'h200 + 32'(4 * n);
      tick();
    end
    if0.retire_valid_i = 1'b0;
    if0.ext_trig_i = 1'b1;
    tick();
    if0.ext_trig_i = 1'b0;
    chk("ext_done", 64'(if0.state_o), 64'd3);
    chk("ext_tidx", 64'(if0.trig_idx_o), 64'd2);
    if0.retire_valid_i = 1'b1;
    if0.pc_i = 32'h2F0;
    tick(2);
    if0.retire_valid_i = 1'b0;
    chk("ext_frozen", 64'(if0.wr_ptr_o), 64'd3);

    // arm with retire writes sample 0; same-index read returns old data
    if0.rd_addr_i = 6'd0;
    if0.trig_mode_i = 2'd2;
    if0.trig_pc_i = 32'h400;
    if0.post_cnt_i = 6'd5;
    if0.arm_i = 1'b1;
    if0.retire_valid_i = 1'b1;
    if0.pc_i = 32'h300;
    tick();
    if0.arm_i = 1'b0;
    if0.retire_valid_i = 1'b0;
    chk("rdw_old", 64'(if0.rd_pc_o), 64'h200);
    chk("arm_wptr", 64'(if0.wr_ptr_o), 64'd1);
    tick();
    chk("rdw_new", 64'(if0.rd_pc_o), 64'h300);

    // PC match -> POST, then arm collides with matching PC in POST
    if0.retire_valid_i = 1'b1;
    if0.pc_i = 32'h400;
    tick();
    chk("pc_post", 64'(if0.state_o), 64'd2);
    chk("pc_tidx", 64'(if0.trig_idx_o), 64'd1);
    if0.arm_i = 1'b1;
    tick();
    chk("prio_post_state", 64'(if0.state_o), 64'd1);
    chk("prio_post_wptr", 64'(if0.wr_ptr_o), 64'd1);
    chk("prio_post_trig", 64'(if0.triggered_o), 64'd0);
    tick();
    if0.arm_i = 1'b0;
    chk("prio_armed_state", 64'(if0.state_o), 64'd1);
    chk("prio_armed_wptr", 64'(if0.wr_ptr_o), 64'd1);
    tick();
    if0.retire_valid_i = 1'b0;
    chk("pc_post2", 64'(if0.state_o), 64'd2);
    chk("pc_wptr2", 64'(if0.wr_ptr_o), 64'd2);

    // PC match with wrap on the 8-deep build
    if1.trig_mode_i = 2'd2;
    if1.trig_pc_i = 32'h140;
    if1.post_cnt_i = 3'd2;
    if1.arm_i = 1'b1;
    tick();
    if1.arm_i = 1'b0;
    for (int n = 0; n < 25; n++) begin
      if1.retire_valid_i = 1'b1;
      if1.pc_i = 32'h100 + 32'(4 * n);
      tick();
      if (n == 16) chk("wrap_post", 64'(if1.state_o), 64'd2);
    end
    if1.retire_valid_i = 1'b0;
    chk("wrap_done", 64'(if1.state_o), 64'd3);
    chk("wrap_flag", 64'(if1.wrapped_o), 64'd1);
    chk("wrap_tidx", 64'(if1.trig_idx_o), 64'd0);
    chk("wrap_wptr", 64'(if1.wr_ptr_o), 64'd3);
    if1.rd_addr_i = 3'd2;
    tick();
    chk("wrap_rd2", 64'(if1.rd_pc_o), 64'h148);
    if1.rd_addr_i = 3'd3;
    tick();
    chk("wrap_oldest", 64'(if1.rd_pc_o), 64'h12C);

    // async reset mid-POST, checked before any further clock edge
    #1;
    rst_n = 1'b0;
    #1;
    chk("arst_state", 64'(if0.state_o), 64'd0);
    chk("arst_wptr", 64'(if0.wr_ptr_o), 64'd0);
    chk("arst_tidx", 64'({if0.trig_idx_o, if0.triggered_o}), 64'd0);
    chk("arst_wrap1", 64'({if1.wrapped_o, if1.wr_ptr_o}), 64'd0);
    tick();
    rst_n = 1'b1;
    tick();

    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end
endmodule
